// File: rtl/fft_pkg.sv
// Shared FFT definitions: constants, state encoding, bit reversal and twiddle ROM contents.
// The inverse-FFT block uses the same package.
package fft_pkg;
    localparam int N      = 256;
    localparam int LOG2N  = 8;
    localparam int DW     = 16;
    localparam int TW     = 16;
    localparam int TW_ONE = 16384;
    localparam int ROUND  = 8192;

    typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

    typedef struct packed {
        logic signed [TW-1:0] re;
        logic signed [TW-1:0] im;
    } twiddle_t;

    function automatic logic [7:0] bitrev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // round(TW_ONE * cos(pi*q/128)) for q = 0..64, from a Q2.30 Taylor series
    function automatic int quarter_cos(input int q);
        longint theta, theta2, term, acc;
        theta  = (64'sd3373259426 * longint'(q)) / 128;
        theta2 = (theta * theta) >>> 30;
        term   = 64'sd1 <<< 30;
        acc    = term;
        for (int i = 0; i < 10; i++) begin
            term = -(((term * theta2) >>> 30) / longint'((2*i+1) * (2*i+2)));
            acc  = acc + term;
        end
        return int'((acc + (64'sd1 <<< 15)) >>> 16);
    endfunction

    // W[k] = cos(2*pi*k/N) - i*sin(2*pi*k/N), k = 0..N/2-1, folded onto one quarter wave
    function automatic twiddle_t twiddle_rom(input int k);
        twiddle_t w;
        if (k <= 64) begin
            w.re = TW'(quarter_cos(k));
            w.im = TW'(-quarter_cos(64 - k));
        end else begin
            w.re = TW'(-quarter_cos(128 - k));
            w.im = TW'(-quarter_cos(k - 64));
        end
        return w;
    endfunction
endpackage

// File: rtl/fft_butterfly.sv
// Combinational radix-2 DIT butterfly: t = b*W (Q1.14, rounded), top/bot = (a +/- t) >>> 1.
module fft_butterfly
    import fft_pkg::*;
(
    input  logic [DW-1:0] i_a_re,
    input  logic [DW-1:0] i_a_im,
    input  logic [DW-1:0] i_b_re,
    input  logic [DW-1:0] i_b_im,
    input  logic [TW-1:0] i_w_re,
    input  logic [TW-1:0] i_w_im,
    output logic [DW-1:0] o_top_re,
    output logic [DW-1:0] o_top_im,
    output logic [DW-1:0] o_bot_re,
    output logic [DW-1:0] o_bot_im
);
    logic signed [31:0] w_br, w_bi, w_wr, w_wi;
    logic signed [31:0] w_p_re, w_p_im;
    logic signed [16:0] w_t_re, w_t_im;
    logic signed [17:0] w_a_re, w_a_im;
    logic signed [17:0] w_sum_re, w_sum_im, w_dif_re, w_dif_im;

    assign w_br = 32'($signed(i_b_re));
    assign w_bi = 32'($signed(i_b_im));
    assign w_wr = 32'($signed(i_w_re));
    assign w_wi = 32'($signed(i_w_im));

    assign w_p_re = w_br * w_wr - w_bi * w_wi;
    assign w_p_im = w_br * w_wi + w_bi * w_wr;

    assign w_t_re = 17'((w_p_re + ROUND) >>> 14);
    assign w_t_im = 17'((w_p_im + ROUND) >>> 14);

    assign w_a_re = 18'($signed(i_a_re));
    assign w_a_im = 18'($signed(i_a_im));

    assign w_sum_re = w_a_re + 18'(w_t_re);
    assign w_sum_im = w_a_im + 18'(w_t_im);
    assign w_dif_re = w_a_re - 18'(w_t_re);
    assign w_dif_im = w_a_im - 18'(w_t_im);

    // Dropping bit 0 is the floor halving; bit 17 is redundant after the halving.
    assign o_top_re = w_sum_re[16:1];
    assign o_top_im = w_sum_im[16:1];
    assign o_bot_re = w_dif_re[16:1];
    assign o_bot_im = w_dif_im[16:1];
endmodule

// File: rtl/fft_256.sv
// Iterative in-place 256-point forward FFT: load in bit-reversed order, 8x128 butterflies, stream bins.
module fft_256
    import fft_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] x_real,
    input  logic [15:0] x_img,
    output logic        out_valid,
    output logic [15:0] y_real,
    output logic [15:0] y_img
);
    state_t     r_state;
    logic [7:0] r_n;
    logic [2:0] r_stage;
    logic [6:0] r_bfly;
    logic [7:0] r_bin;

    logic [DW-1:0] r_mem_re [N];
    logic [DW-1:0] r_mem_im [N];

    logic [TW-1:0] w_rom_re [N/2];
    logic [TW-1:0] w_rom_im [N/2];

    for (genvar gk = 0; gk < N/2; gk++) begin : g_rom
        localparam twiddle_t W_K = twiddle_rom(gk);
        assign w_rom_re[gk] = W_K.re;
        assign w_rom_im[gk] = W_K.im;
    end

    logic [7:0] w_b8, w_half, w_j, w_top, w_bot;
    logic [6:0] w_tw_idx;

    always_comb begin
        w_b8     = {1'b0, r_bfly};
        w_half   = 8'd1 << r_stage;
        w_j      = w_b8 & (w_half - 8'd1);
        w_top    = ((w_b8 >> r_stage) << ({1'b0, r_stage} + 4'd1)) + w_j;
        w_bot    = w_top + w_half;
        w_tw_idx = 7'(w_j << (3'd7 - r_stage));
    end

    logic [DW-1:0] w_top_re, w_top_im, w_bot_re, w_bot_im;

    fft_butterfly u_bfly (
        .i_a_re   (r_mem_re[w_top]),
        .i_a_im   (r_mem_im[w_top]),
        .i_b_re   (r_mem_re[w_bot]),
        .i_b_im   (r_mem_im[w_bot]),
        .i_w_re   (w_rom_re[w_tw_idx]),
        .i_w_im   (w_rom_im[w_tw_idx]),
        .o_top_re (w_top_re),
        .o_top_im (w_top_im),
        .o_bot_re (w_bot_re),
        .o_bot_im (w_bot_im)
    );

    // Memory holds no reset: contents are overwritten by every frame before use.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == LOAD && in_valid) begin
                r_mem_re[bitrev8(r_n)] <= x_real;
                r_mem_im[bitrev8(r_n)] <= x_img;
            end else if (r_state == COMPUTE) begin
                r_mem_re[w_top] <= w_top_re;
                r_mem_im[w_top] <= w_top_im;
                r_mem_re[w_bot] <= w_bot_re;
                r_mem_im[w_bot] <= w_bot_im;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= LOAD;
            r_n       <= '0;
            r_stage   <= '0;
            r_bfly    <= '0;
            r_bin     <= '0;
            out_valid <= 1'b0;
            y_real    <= '0;
            y_img     <= '0;
        end else begin
            out_valid <= 1'b0;
            y_real    <= '0;
            y_img     <= '0;
            case (r_state)
                LOAD: begin
                    if (in_valid) begin
                        r_n <= r_n + 8'd1;
                        if (r_n == 8'd255) r_state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    r_bfly <= r_bfly + 7'd1;
                    if (r_bfly == 7'd127) begin
                        r_stage <= r_stage + 3'd1;
                        if (r_stage == 3'd7) r_state <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    out_valid <= 1'b1;
                    y_real    <= r_mem_re[r_bin];
                    y_img     <= r_mem_im[r_bin];
                    r_bin     <= r_bin + 8'd1;
                    if (r_bin == 8'd255) r_state <= LOAD;
                end
                default: r_state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_256.sv
// Randomized self-checking bench for fft_256 against a floating-twiddle reference FFT.
module tb_fft_256;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] x_real, x_img;
    logic        out_valid;
    logic [15:0] y_real, y_img;

    fft_256 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .x_real    (x_real),
        .x_img     (x_img),
        .out_valid (out_valid),
        .y_real    (y_real),
        .y_img     (y_img)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    int xr [256], xi [256];
    int er [256], ei [256];
    int yr [256], yi [256];

    task automatic chk(input string tag, input int got, input int exp, input int tol = 0);
        n_tests++;
        if (got > exp + tol || got < exp - tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    function automatic int rev8(input int v);
        int r = 0;
        for (int i = 0; i < 8; i++) if ((v & (1 << i)) != 0) r |= 1 << (7 - i);
        return r;
    endfunction

    function automatic longint wrap16(input longint v);
        logic signed [15:0] t;
        t = v[15:0];
        return longint'(t);
    endfunction

    // Textbook in-place DIT FFT with per-stage halving and Q1.14 rounded twiddles.
    task automatic model();
        longint ar [256], ai [256];
        for (int n = 0; n < 256; n++) begin
            ar[rev8(n)] = xr[n];
            ai[rev8(n)] = xi[n];
        end
        for (int half = 1; half < 256; half *= 2) begin
            for (int base = 0; base < 256; base += 2 * half) begin
                for (int j = 0; j < half; j++) begin
                    real    ang;
                    longint wr, wi, br, bi, tr, ti, at, bt;
                    ang = 2.0 * 3.141592653589793 * real'(j * (128 / half)) / 256.0;
                    wr  = longint'(int'(16384.0 * $cos(ang)));
                    wi  = -longint'(int'(16384.0 * $sin(ang)));
                    br  = ar[base + j + half];
                    bi  = ai[base + j + half];
                    tr  = (br * wr - bi * wi + 8192) >>> 14;
                    ti  = (br * wi + bi * wr + 8192) >>> 14;
                    at  = ar[base + j];
                    bt  = ai[base + j];
                    ar[base + j]        = wrap16((at + tr) >>> 1);
                    ai[base + j]        = wrap16((bt + ti) >>> 1);
                    ar[base + j + half] = wrap16((at - tr) >>> 1);
                    ai[base + j + half] = wrap16((bt - ti) >>> 1);
                end
            end
        end
        for (int k = 0; k < 256; k++) begin
            er[k] = int'(ar[k]);
            ei[k] = int'(ai[k]);
        end
    endtask

    task automatic fill(input int kind);
        for (int n = 0; n < 256; n++) begin
            case (kind)
                0: begin xr[n] = (n == 0) ? 256 : 0;   xi[n] = 0; end
                1: begin xr[n] = 256;                  xi[n] = 0; end
                2: begin xr[n] = (n == 1) ? 16384 : 0; xi[n] = 0; end
                default: begin
                    xr[n] = int'($urandom_range(0, 8190)) - 4095;
                    xi[n] = int'($urandom_range(0, 8190)) - 4095;
                end
            endcase
        end
    endtask

    task automatic expect_impulse();
        for (int k = 0; k < 256; k++) begin er[k] = 1; ei[k] = 0; end
    endtask

    task automatic expect_dc();
        for (int k = 0; k < 256; k++) begin er[k] = (k == 0) ? 256 : 0; ei[k] = 0; end
    endtask

    // Called positioned at a negedge; returns at a negedge with in_valid low queued.
    task automatic send_frame(input bit gapped, output int e_last);
        e_last = 0;
        for (int n = 0; n < 256; n++) begin
            in_valid = 1'b1;
            x_real   = 16'(xr[n]);
            x_img    = 16'(xi[n]);
            if (n == 255) e_last = cyc + 1;
            @(negedge clk);
            if (gapped) begin
                in_valid = 1'b0;
                x_real   = 16'($urandom);
                x_img    = 16'($urandom);
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic noise_drive();
        in_valid = 1'($urandom);
        x_real   = 16'($urandom);
        x_img    = 16'($urandom);
    endtask

    // Returns at the negedge where bin 255 is visible, so a new frame can start right away.
    task automatic collect(input string tag, input bit noise, input int e_last);
        int guard = 0;
        int nv = 0;
        while (!out_valid && guard < 3000) begin
            if (noise) noise_drive();
            @(negedge clk);
            guard++;
        end
        chk({tag, ".latency"}, cyc - e_last, 1025);
        for (int k = 0; k < 256; k++) begin
            yr[k] = int'($signed(y_real));
            yi[k] = int'($signed(y_img));
            nv += int'(out_valid);
            if (k < 255) begin
                if (noise) noise_drive();
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        chk({tag, ".valid_cycles"}, nv, 256);
    endtask

    task automatic cmp_bins(input string tag, input int tol);
        for (int k = 0; k < 256; k++) begin
            chk($sformatf("%s.re[%0d]", tag, k), yr[k], er[k], tol);
            chk($sformatf("%s.im[%0d]", tag, k), yi[k], ei[k], tol);
        end
    endtask

    task automatic idle_check(input string tag);
        in_valid = 1'b0;
        @(negedge clk);
        chk({tag, ".idle_valid"}, int'(out_valid), 0);
        chk({tag, ".idle_y"}, int'(y_real) | int'(y_img), 0);
    endtask

    initial begin
        int e_last;
        int guard;
        rst      = 1'b1;
        in_valid = 1'b0;
        x_real   = '0;
        x_img    = '0;
        repeat (3) @(negedge clk);
        chk("reset.out_valid", int'(out_valid), 0);
        chk("reset.y", int'(y_real) | int'(y_img), 0);
        rst = 1'b0;
        @(negedge clk);

        fill(0); send_frame(1'b0, e_last); collect("impulse", 1'b0, e_last);
        expect_impulse(); cmp_bins("impulse", 0); idle_check("impulse");

        fill(0); send_frame(1'b1, e_last); collect("gapped", 1'b0, e_last);
        expect_impulse(); cmp_bins("gapped", 0); idle_check("gapped");

        fill(1); send_frame(1'b0, e_last); collect("dc", 1'b0, e_last);
        expect_dc(); cmp_bins("dc", 0); idle_check("dc");

        fill(2); send_frame(1'b0, e_last); collect("tone", 1'b0, e_last);
        chk("tone.bin0.re", yr[0], 64, 1);     chk("tone.bin0.im", yi[0], 0, 1);
        chk("tone.bin64.re", yr[64], 0, 1);    chk("tone.bin64.im", yi[64], -64, 1);
        chk("tone.bin128.re", yr[128], -64, 1); chk("tone.bin128.im", yi[128], 0, 1);
        chk("tone.bin192.re", yr[192], 0, 1);  chk("tone.bin192.im", yi[192], 64, 1);
        model(); cmp_bins("tone", 1); idle_check("tone");

        // Random frame with bus noise while busy, then a DC frame with no gap after bin 255.
        fill(3); model();
        send_frame(1'b0, e_last); collect("rand", 1'b1, e_last);
        cmp_bins("rand", 1);
        fill(1); send_frame(1'b0, e_last); collect("b2b_dc", 1'b0, e_last);
        expect_dc(); cmp_bins("b2b_dc", 0); idle_check("b2b_dc");

        // Reset in the middle of COMPUTE.
        fill(3); send_frame(1'b0, e_last);
        repeat (499) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_compute.out_valid", int'(out_valid), 0);
        chk("rst_compute.y", int'(y_real) | int'(y_img), 0);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of OUTPUT.
        fill(3); send_frame(1'b0, e_last);
        guard = 0;
        while (!out_valid && guard < 3000) begin @(negedge clk); guard++; end
        chk("rst_output.reached", int'(out_valid), 1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_output.out_valid", int'(out_valid), 0);
        chk("rst_output.y", int'(y_real) | int'(y_img), 0);
        rst = 1'b0;
        @(negedge clk);

        // Partial load, then reset: the sample counter must restart.
        fill(3);
        for (int n = 0; n < 100; n++) begin
            in_valid = 1'b1; x_real = 16'(xr[n]); x_img = 16'(xi[n]);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        fill(0); send_frame(1'b0, e_last); collect("post_rst", 1'b0, e_last);
        expect_impulse(); cmp_bins("post_rst", 0); idle_check("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
